// File: rtl/gat_sched_pkg.sv
// Shared types and sizing helpers for the GAT layer scheduler.
package gat_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    RUN       = 2'd2,
    READOUT   = 2'd3
  } sched_state_e;

  localparam int FEAT_WORDS_DEFAULT = 2708 * 16;

  function automatic int feat_words(input int n_sub, input int n_feat);
    return n_sub * n_feat;
  endfunction

  function automatic int addr_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/gat_sched_obuf.sv
// Credit-based output FIFO for feature readout; a valid pipe of RD_LAT stages
// tracks reads in flight so the FIFO can never overflow.
module gat_sched_obuf
  import gat_sched_pkg::*;
#(
  parameter int W      = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         credit_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [W-1:0]      mem_q [DEPTH];
  logic [W-1:0]      mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     inflight;
  logic              push, do_pop;

  assign push   = vpipe_q[RD_LAT-1];
  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    vpipe_d  = RD_LAT'({vpipe_q, issue});
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(vpipe_q[i]);
    end
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q] = din;
    end
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
  end

  // Reads already issued own a slot, so issue only while a slot remains free.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
  assign dout      = mem_q[rd_q];
  assign empty     = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vpipe_q <= vpipe_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/gat_layer_scheduler.sv
// Sequences one or two GAT layers: host load handshake, gat_top run, feature readout.
// Optional watchdog on WAIT_LOAD/RUN enabled by defining SCHED_TIMEOUT_EN.
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_LOAD | host loading BRAMs for the current layer
//   RUN       | gat_top computing; waiting for a fresh gat_ready
//   READOUT   | streaming FEAT_WORDS feature words to m_t*
module gat_layer_scheduler
  import gat_sched_pkg::*;
#(
  parameter int TOP_WIDTH          = 32,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int FEAT_WORDS         = feat_words(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
  parameter int NEW_FEATURE_ADDR_W = addr_w(FEAT_WORDS),
  parameter int RD_LAT             = 2,
  parameter int OBUF_DEPTH         = 4,
  parameter int TIMEOUT_CYC        = 2 ** 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            cfg_two_layer,
  output logic                            busy,
  output logic                            done,
  output logic                            ld_req,
  output logic                            ld_layer,
  input  logic                            h_data_bram_load_done,
  input  logic                            h_node_info_bram_load_done,
  input  logic                            wgt_bram_load_done,
  output logic                            gat_layer,
  input  logic                            gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            err
);

  localparam int AW     = NEW_FEATURE_ADDR_W;
  localparam int LAST_I = FEAT_WORDS - 1;
  localparam logic [AW:0]   WORDS_C = FEAT_WORDS[AW:0];
  localparam logic [AW-1:0] LAST_C  = LAST_I[AW-1:0];

  sched_state_e  state_q, state_d;
  logic          layer_q, layer_d;
  logic          two_q, two_d;
  logic          wgt_prev_q, wgt_prev_d;
  logic          rdy_low_q, rdy_low_d;
  logic [AW:0]   rd_idx_q, rd_idx_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          done_q, done_d;

  logic          issue, hs, credit_ok, obuf_empty, last_word;

`ifdef SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  assign last_word = (out_idx_q == LAST_C);
  assign hs        = m_tvalid && m_tready;
  assign issue     = (state_q == READOUT) && (rd_idx_q < WORDS_C) && credit_ok;

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    two_d      = two_q;
    wgt_prev_d = wgt_bram_load_done;
    rdy_low_d  = rdy_low_q;
    rd_idx_d   = rd_idx_q;
    out_idx_d  = out_idx_q;
    done_d     = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          two_d   = cfg_two_layer;
          layer_d = 1'b0;
          state_d = WAIT_LOAD;
`ifdef SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      WAIT_LOAD: begin
        if (layer_q == 1'b0) begin
          if (h_data_bram_load_done && h_node_info_bram_load_done && wgt_bram_load_done) begin
            state_d   = RUN;
            rdy_low_d = 1'b0;
          end
        end else if (wgt_bram_load_done && !wgt_prev_q) begin
          state_d   = RUN;
          rdy_low_d = 1'b0;
        end
      end
      RUN: begin
        if (!gat_ready) begin
          rdy_low_d = 1'b1;
        end else if (rdy_low_q) begin
          state_d   = READOUT;
          rd_idx_d  = '0;
          out_idx_d = '0;
        end
      end
      READOUT: begin
        if (issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
        if (hs) begin
          out_idx_d = out_idx_q + 1'b1;
          if (last_word) begin
            rd_idx_d  = '0;
            out_idx_d = '0;
            if (two_q && (layer_q == 1'b0)) begin
              layer_d    = 1'b1;
              state_d    = WAIT_LOAD;
              // a weight flag still high from layer 0 must not count as a new load
              wgt_prev_d = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SCHED_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == WAIT_LOAD) || (state_q == RUN)) begin
      if (tmo_q == TMO_LIMIT) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (state_d == state_q) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      layer_q    <= 1'b0;
      two_q      <= 1'b0;
      wgt_prev_q <= 1'b0;
      rdy_low_q  <= 1'b0;
      rd_idx_q   <= '0;
      out_idx_q  <= '0;
      done_q     <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      two_q      <= two_d;
      wgt_prev_q <= wgt_prev_d;
      rdy_low_q  <= rdy_low_d;
      rd_idx_q   <= rd_idx_d;
      out_idx_q  <= out_idx_d;
      done_q     <= done_d;
`ifdef SCHED_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  gat_sched_obuf #(
    .W      (NEW_FEATURE_WIDTH),
    .DEPTH  (OBUF_DEPTH),
    .RD_LAT (RD_LAT)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .din       (feat_bram_dout),
    .pop       (hs),
    .dout      (m_tdata),
    .empty     (obuf_empty),
    .credit_ok (credit_ok)
  );

  // Once every word is issued the address parks on the last word instead of wrapping.
  assign feat_bram_addrb = {(rd_idx_q < WORDS_C) ? rd_idx_q[AW-1:0] : LAST_C, 2'b00};

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ld_req    = (state_q == WAIT_LOAD);
  assign ld_layer  = layer_q;
  assign gat_layer = layer_q;
  assign m_tvalid  = !obuf_empty;
  assign m_tlast   = m_tvalid && last_word;

`ifdef SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Directed bench for gat_layer_scheduler with a small layer (16 words) and RD_LAT=3.
module tb_gat_layer_scheduler;

  localparam int NSG = 4;
  localparam int NFO = 4;
  localparam int FW  = NSG * NFO;
  localparam int AW  = 4;
  localparam int RDL = 3;
  localparam int OBD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cfg_two_layer = 1'b0;
  logic          h_data = 1'b0;
  logic          h_node = 1'b0;
  logic          wgt = 1'b0;
  logic          gat_ready = 1'b0;
  logic          m_tready = 1'b0;
  logic          busy, done, ld_req, ld_layer, gat_layer, m_tvalid, m_tlast, err;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout;
  logic [31:0]   m_tdata;
  logic [31:0]   pipe [RDL];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  gat_layer_scheduler #(
    .NUM_SUBGRAPHS   (NSG),
    .NUM_FEATURE_OUT (NFO),
    .RD_LAT          (RDL),
    .OBUF_DEPTH      (OBD),
    .TIMEOUT_CYC     (64)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .start                      (start),
    .cfg_two_layer              (cfg_two_layer),
    .busy                       (busy),
    .done                       (done),
    .ld_req                     (ld_req),
    .ld_layer                   (ld_layer),
    .h_data_bram_load_done      (h_data),
    .h_node_info_bram_load_done (h_node),
    .wgt_bram_load_done         (wgt),
    .gat_layer                  (gat_layer),
    .gat_ready                  (gat_ready),
    .feat_bram_addrb            (feat_bram_addrb),
    .feat_bram_dout             (feat_bram_dout),
    .m_tdata                    (m_tdata),
    .m_tvalid                   (m_tvalid),
    .m_tready                   (m_tready),
    .m_tlast                    (m_tlast),
    .err                        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] feat(input int i, input int layer);
    return 32'hC0DE_0000 + 32'(layer) * 32'h0010_0000 + 32'(i) * 32'd7 + 32'd1;
  endfunction

  // Feature BRAM model: RD_LAT-cycle pipelined read, contents depend on layer.
  always @(posedge clk) begin
    pipe[0] <= feat(int'(feat_bram_addrb >> 2), int'(gat_layer));
    for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
  end
  assign feat_bram_dout = pipe[RDL-1];

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_flags(input logic h, input logic n, input logic w);
    h_data = h; h_node = n; wgt = w;
  endtask

  task automatic pulse_start(input logic two);
    cfg_two_layer = two;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Collects words; tallies are checked by the calling scenario.
  task automatic drain(input int exp_layer, input int duty, input int max_words,
                       output int nw, output int bad_data, output int bad_last, output int stall_err);
    int cyc;
    logic stalled;
    logic [31:0] held_d;
    logic held_l;
    nw = 0; bad_data = 0; bad_last = 0; stall_err = 0;
    cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (nw < max_words && cyc < 3000) begin
      m_tready = ($urandom_range(99) < duty);
      if (stalled && (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l)) stall_err++;
      if (m_tvalid === 1'b1) begin
        if (m_tdata !== feat(nw, exp_layer)) bad_data++;
        if (m_tlast !== (nw == FW - 1)) bad_last++;
        if (m_tready) begin
          nw++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d = m_tdata;
          held_l = m_tlast;
        end
      end
      tick();
      cyc++;
    end
    m_tready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; cfg_two_layer = 1'b0; gat_ready = 1'b0; m_tready = 1'b0;
    set_flags(0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({busy, done, ld_req, ld_layer, gat_layer, m_tvalid, m_tlast, err} !== 8'b0) begin
      fails++;
      $display("FAIL reset_outs: got %b want 00000000",
               {busy, done, ld_req, ld_layer, gat_layer, m_tvalid, m_tlast, err});
    end
    tests++;
    if (feat_bram_addrb !== '0) begin
      fails++;
      $display("FAIL reset_addr: got %0d want 0", feat_bram_addrb);
    end
  endtask

  task automatic test_single_layer();
    int nw, bd, bl, se, d0;
    set_flags(1, 1, 1);
    gat_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(1'b0);
    tests++;
    if (ld_req !== 1'b1 || busy !== 1'b1 || ld_layer !== 1'b0) begin
      fails++;
      $display("FAIL single_wait_load: ld_req=%b busy=%b ld_layer=%b want 1 1 0", ld_req, busy, ld_layer);
    end
    tick();
    tests++;
    if (ld_req !== 1'b0 || busy !== 1'b1 || gat_layer !== 1'b0) begin
      fails++;
      $display("FAIL single_run_entry: ld_req=%b busy=%b gat_layer=%b want 0 1 0", ld_req, busy, gat_layer);
    end
    repeat (50) tick();
    tests++;
    if (feat_bram_addrb !== '0 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_run_hold: addrb=%0d tvalid=%b want 0 0", feat_bram_addrb, m_tvalid);
    end
    gat_ready = 1'b1;
    drain(0, 100, FW, nw, bd, bl, se);
    tests++;
    if (nw != FW) begin fails++; $display("FAIL single_words: got %0d want %0d", nw, FW); end
    tests++;
    if (bd != 0) begin fails++; $display("FAIL single_data: %0d bad words want 0", bd); end
    tests++;
    if (bl != 0) begin fails++; $display("FAIL single_tlast: %0d bad tlast want 0", bl); end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done: done=%b busy=%b want 1 0", done, busy);
    end
    gat_ready = 1'b0;
    tick();
    tests++;
    if (done !== 1'b0 || m_tvalid !== 1'b0 || (done_cnt - d0) != 1) begin
      fails++;
      $display("FAIL single_done_pulse: done=%b tvalid=%b pulses=%0d want 0 0 1", done, m_tvalid, done_cnt - d0);
    end
  endtask

  task automatic test_two_layer();
    int nw, bd, bl, se, d0;
    set_flags(1, 1, 1);
    gat_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(1'b1);
    tick();
    pulse_start(1'b0);
    repeat (4) tick();
    gat_ready = 1'b1;
    drain(0, 100, FW, nw, bd, bl, se);
    tests++;
    if (nw != FW || bd != 0 || bl != 0) begin
      fails++;
      $display("FAIL two_layer0: words=%0d bad_data=%0d bad_last=%0d want %0d 0 0", nw, bd, bl, FW);
    end
    tests++;
    if (ld_req !== 1'b1 || ld_layer !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL two_wait_l1: ld_req=%b ld_layer=%b done=%b busy=%b want 1 1 0 1", ld_req, ld_layer, done, busy);
    end
    gat_ready = 1'b0;
    h_data = 1'b0;
    h_node = 1'b0;
    repeat (10) tick();
    tests++;
    if (ld_req !== 1'b1) begin fails++; $display("FAIL two_stale_wgt: ld_req=%b want 1", ld_req); end
    wgt = 1'b0;
    tick();
    tests++;
    if (ld_req !== 1'b1) begin fails++; $display("FAIL two_wgt_low: ld_req=%b want 1", ld_req); end
    wgt = 1'b1;
    tick();
    tests++;
    if (ld_req !== 1'b0 || gat_layer !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL two_run_l1: ld_req=%b gat_layer=%b busy=%b want 0 1 1", ld_req, gat_layer, busy);
    end
    repeat (3) tick();
    gat_ready = 1'b1;
    drain(1, 100, FW, nw, bd, bl, se);
    tests++;
    if (nw != FW || bd != 0 || bl != 0) begin
      fails++;
      $display("FAIL two_layer1: words=%0d bad_data=%0d bad_last=%0d want %0d 0 0", nw, bd, bl, FW);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL two_done: done=%b busy=%b want 1 0", done, busy);
    end
    gat_ready = 1'b0;
    tick();
    tests++;
    if ((done_cnt - d0) != 1) begin fails++; $display("FAIL two_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_stale_ready();
    int nw, bd, bl, se;
    set_flags(1, 1, 1);
    gat_ready = 1'b1;
    pulse_start(1'b0);
    tick();
    repeat (5) tick();
    tests++;
    if (feat_bram_addrb !== '0 || m_tvalid !== 1'b0 || busy !== 1'b1 || ld_req !== 1'b0) begin
      fails++;
      $display("FAIL stale_high: addrb=%0d tvalid=%b busy=%b ld_req=%b want 0 0 1 0", feat_bram_addrb, m_tvalid, busy, ld_req);
    end
    gat_ready = 1'b0;
    repeat (3) tick();
    tests++;
    if (feat_bram_addrb !== '0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stale_low: addrb=%0d busy=%b want 0 1", feat_bram_addrb, busy);
    end
    gat_ready = 1'b1;
    drain(0, 100, FW, nw, bd, bl, se);
    tests++;
    if (nw != FW || bd != 0 || done !== 1'b1) begin
      fails++;
      $display("FAIL stale_readout: words=%0d bad_data=%0d done=%b want %0d 0 1", nw, bd, done, FW);
    end
    gat_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int nw, bd, bl, se;
    set_flags(1, 1, 1);
    gat_ready = 1'b0;
    pulse_start(1'b0);
    repeat (3) tick();
    gat_ready = 1'b1;
    drain(0, 30, FW, nw, bd, bl, se);
    tests++;
    if (nw != FW) begin fails++; $display("FAIL bp_words: got %0d want %0d", nw, FW); end
    tests++;
    if (bd != 0 || bl != 0) begin
      fails++;
      $display("FAIL bp_data: bad_data=%0d bad_last=%0d want 0 0", bd, bl);
    end
    tests++;
    if (se != 0) begin fails++; $display("FAIL bp_stall_stable: %0d unstable cycles want 0", se); end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: done=%b busy=%b want 1 0", done, busy);
    end
    gat_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int nw, bd, bl, se, d0;
    set_flags(1, 1, 1);
    gat_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(1'b0);
    repeat (3) tick();
    gat_ready = 1'b1;
    drain(0, 100, 5, nw, bd, bl, se);
    tests++;
    if (nw != 5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre: words=%0d busy=%b want 5 1", nw, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, ld_req, gat_layer, m_tvalid, m_tlast, err} !== 7'b0 || feat_bram_addrb !== '0) begin
      fails++;
      $display("FAIL mid_async_reset: outs=%b addrb=%0d want 0000000 0",
               {busy, done, ld_req, gat_layer, m_tvalid, m_tlast, err}, feat_bram_addrb);
    end
    tick();
    rst_n = 1'b1;
    gat_ready = 1'b0;
    tick();
    pulse_start(1'b0);
    repeat (3) tick();
    gat_ready = 1'b1;
    drain(0, 100, FW, nw, bd, bl, se);
    tests++;
    if (nw != FW || bd != 0 || bl != 0) begin
      fails++;
      $display("FAIL mid_restart: words=%0d bad_data=%0d bad_last=%0d want %0d 0 0", nw, bd, bl, FW);
    end
    gat_ready = 1'b0;
    tick();
    tests++;
    if ((done_cnt - d0) != 1) begin fails++; $display("FAIL mid_done_count: got %0d want 1", done_cnt - d0); end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n, d0;
    set_flags(1, 1, 1);
    gat_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(1'b0);
    tick();
    n = 1;
    while (busy === 1'b1 && n < 500) begin
      tick();
      n++;
    end
    tests++;
    if (n != 65 || err !== 1'b1 || (done_cnt - d0) != 0) begin
      fails++;
      $display("FAIL timeout: idle_at=%0d err=%b dones=%0d want 65 1 0", n, err, done_cnt - d0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_layer();
    test_two_layer();
    test_stale_ready();
    test_backpressure();
    test_reset_mid();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
